pll_cfg_writer: RTL and testbench



---
 rtl/pll_cfg_pkg.sv | 45 ++++
 rtl/sync2.sv | 29 ++
 rtl/pll_cfg_writer.sv | 215 +++++++++++++++++++++
 tb/tb_pll_cfg_writer.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the PLL reconfiguration writer.
// Holds the altera_pll_reconfig register addresses, the bit layout of the
// 18-bit encoded counter words, the writer FSM state type and a helper that
// packs one C-counter write word.
package pll_cfg_pkg;

    // Reconfiguration register map (word addresses on the management port).
    localparam logic [5:0] RegMode   = 6'h00;
    localparam logic [5:0] RegStatus = 6'h01;
    localparam logic [5:0] RegStart  = 6'h02;
    localparam logic [5:0] RegN      = 6'h03;
    localparam logic [5:0] RegM      = 6'h04;
    localparam logic [5:0] RegC      = 6'h05;
    localparam logic [5:0] RegDps    = 6'h06;
    localparam logic [5:0] RegK      = 6'h07;

    // Encoded counter word: {bypass, odd, high[7:0], low[7:0]}.
    localparam int unsigned CntW       = 18;
    localparam int unsigned CntBypassB = 17;
    localparam int unsigned CntOddB    = 16;
    localparam int unsigned CntHighMsb = 15;
    localparam int unsigned CntHighLsb = 8;
    localparam int unsigned CntLowMsb  = 7;
    localparam int unsigned CntLowLsb  = 0;

    // Counter-select field that sits above the counter word in a C write.
    localparam int unsigned CSelW = 5;

    localparam logic [31:0] ModeWaitreq = 32'h0000_0000;
    localparam logic [31:0] StartGo     = 32'h0000_0001;

    typedef enum logic [1:0] {
        StIdle,
        StWr,
        StWaitUnlock,
        StWaitLock
    } state_e;

    // C-counter write word: {9'b0, select[4:0], counter[17:0]}.
    function automatic logic [31:0] c_word(input logic [CSelW-1:0] sel,
                                           input logic [CntW-1:0]  cnt);
        return {9'b0, sel, cnt};
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// Ports:
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset, output clears to 0
//   d_i    - asynchronous input level
//   q_o    - synchronized level, two clk_i cycles of latency
module sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_cfg_writer.sv
// Avalon-MM master for the fractional PLL dynamic reconfiguration port.
// On an accepted request it latches the encoded N/M/K/C values, writes the
// mode, N, M, (K), C0..C[NUM_C-1] and start registers back to back, then
// waits for the PLL to drop and regain lock, flagging a sticky error when
// lock does not return in time.
// Ports:
//   clk_i, rst_ni          - system clock, asynchronous active-low reset
//   req_i                  - single-cycle start request, honoured only when idle
//   n_cnt_i, m_cnt_i       - encoded N and M counters
//   k_frac_i               - M fractional value
//   c_cnt_i                - encoded C counters, C0 in the low 18 bits
//   busy_o                 - high from acceptance until done
//   done_o                 - one-cycle pulse at the end of a sequence
//   err_o                  - sticky lock-timeout flag, cleared on next accept
//   pll_locked_i           - PLL lock, asynchronous to clk_i
//   mgmt_address_o, mgmt_write_o, mgmt_writedata_o, mgmt_waitrequest_i
//                          - reconfiguration management write port
module pll_cfg_writer
    import pll_cfg_pkg::*;
#(
    parameter int unsigned NUM_C        = 3,
    parameter int unsigned WITH_FRAC    = 1,
    parameter int unsigned UNLOCK_WIN   = 64,
    parameter int unsigned LOCK_TIMEOUT = 1048576
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic [CntW-1:0]       n_cnt_i,
    input  logic [CntW-1:0]       m_cnt_i,
    input  logic [31:0]           k_frac_i,
    input  logic [NUM_C*CntW-1:0] c_cnt_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    input  logic                  pll_locked_i,
    output logic [5:0]            mgmt_address_o,
    output logic                  mgmt_write_o,
    output logic [31:0]           mgmt_writedata_o,
    input  logic                  mgmt_waitrequest_i
);

    localparam int unsigned FracWr = (WITH_FRAC != 0) ? 1 : 0;
    // Index of the first C write; mode, N, M and optionally K come before it.
    localparam int unsigned CBase  = 3 + FracWr;
    localparam int unsigned NumWr  = CBase + NUM_C + 1;
    localparam int unsigned IdxW   = $clog2(NumWr);
    localparam int unsigned TmrMax = (UNLOCK_WIN > LOCK_TIMEOUT) ? UNLOCK_WIN : LOCK_TIMEOUT;
    localparam int unsigned TmrW   = $clog2(TmrMax + 1);

    localparam logic [IdxW-1:0] IdxLast    = IdxW'(NumWr - 1);
    localparam logic [TmrW-1:0] UnlockLast = TmrW'(UNLOCK_WIN - 1);
    localparam logic [TmrW-1:0] LockLast   = TmrW'(LOCK_TIMEOUT - 1);

    state_e                  state_q, state_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [TmrW-1:0]         tmr_q, tmr_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [CntW-1:0]         n_q, m_q;
    logic [31:0]             k_q;
    logic [NUM_C*CntW-1:0]   c_q;
    logic                    latch_en;
    logic                    locked_s;
    logic [TmrW-1:0]         tmr_sat;

    logic [5:0]              wr_addr;
    logic [31:0]             wr_data;

    logic [NUM_C-1:0]        c_hit;
    logic [31:0]             c_or [NUM_C+1];

    sync2 u_lock_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (pll_locked_i),
        .q_o    (locked_s)
    );

    // Select the C write word matching the current list index; at most one hits.
    assign c_or[0] = '0;
    for (genvar g = 0; g < NUM_C; g++) begin : g_cword
        assign c_hit[g]  = (idx_q == IdxW'(CBase + g));
        assign c_or[g+1] = c_or[g] |
                           (c_hit[g] ? c_word(CSelW'(g), c_q[g*CntW +: CntW]) : 32'h0);
    end

    // Address/data for the current write-list entry.
    always_comb begin
        wr_addr = RegMode;
        wr_data = ModeWaitreq;
        if (idx_q == IdxW'(1)) begin
            wr_addr = RegN;
            wr_data = {14'b0, n_q};
        end else if (idx_q == IdxW'(2)) begin
            wr_addr = RegM;
            wr_data = {14'b0, m_q};
        end else if ((FracWr == 1) && (idx_q == IdxW'(3))) begin
            wr_addr = RegK;
            wr_data = k_q;
        end else if (idx_q == IdxLast) begin
            wr_addr = RegStart;
            wr_data = StartGo;
        end else if (|c_hit) begin
            wr_addr = RegC;
            wr_data = c_or[NUM_C];
        end
    end

    // Outputs come straight from registered state, so the async reset
    // removes the write strobe in the same cycle it is asserted.
    always_comb begin
        mgmt_write_o     = (state_q == StWr);
        mgmt_address_o   = '0;
        mgmt_writedata_o = '0;
        if (state_q == StWr) begin
            mgmt_address_o   = wr_addr;
            mgmt_writedata_o = wr_data;
        end
    end

    assign tmr_sat = (tmr_q == {TmrW{1'b1}}) ? tmr_q : tmr_q + TmrW'(1);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tmr_d    = tmr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        latch_en = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    latch_en = 1'b1;
                    busy_d   = 1'b1;
                    err_d    = 1'b0;
                    idx_d    = '0;
                    state_d  = StWr;
                end
            end
            StWr: begin
                if (!mgmt_waitrequest_i) begin
                    if (idx_q == IdxLast) begin
                        idx_d   = '0;
                        tmr_d   = '0;
                        state_d = StWaitUnlock;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StWaitUnlock: begin
                // Move on when lock drops, or give up waiting for the drop.
                if (!locked_s || (tmr_q == UnlockLast)) begin
                    tmr_d   = '0;
                    state_d = StWaitLock;
                end else begin
                    tmr_d = tmr_sat;
                end
            end
            StWaitLock: begin
                if (locked_s) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else if (tmr_q == LockLast) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    tmr_d = tmr_sat;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            idx_q   <= '0;
            tmr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            n_q     <= '0;
            m_q     <= '0;
            k_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (latch_en) begin
                n_q <= n_cnt_i;
                m_q <= m_cnt_i;
                k_q <= k_frac_i;
                c_q <= c_cnt_i;
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_pll_cfg_writer.sv
// Scoreboard bench for pll_cfg_writer: expected writes are queued when a
// request is issued; monitors compare every presented write against the queue.
module tb_pll_cfg_writer;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [17:0] n_cnt, m_cnt;
    logic [31:0] k_frac;
    logic [53:0] c_cnt;
    logic        busy, done, err;
    logic        pll_locked;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest;

    logic        req2;
    logic [17:0] n_cnt2, m_cnt2;
    logic [31:0] k_frac2;
    logic [53:0] c_cnt2;
    logic        busy2, done2, err2;
    logic        pll_locked2;
    logic [5:0]  mgmt_address2;
    logic        mgmt_write2;
    logic [31:0] mgmt_writedata2;
    logic        mgmt_waitrequest2;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int wr2_cnt = 0;
    int k2_seen = 0;
    int stall = 0;
    int hold = 0;
    int lock_mode = 2;
    int start_cyc = 0;
    int drop_at = -1;
    int rise_at = -1;

    logic [37:0] exp_q[$];
    logic [37:0] exp2_q[$];

    pll_cfg_writer #(
        .NUM_C        (3),
        .WITH_FRAC    (1),
        .UNLOCK_WIN   (64),
        .LOCK_TIMEOUT (100)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .req_i              (req),
        .n_cnt_i            (n_cnt),
        .m_cnt_i            (m_cnt),
        .k_frac_i           (k_frac),
        .c_cnt_i            (c_cnt),
        .busy_o             (busy),
        .done_o             (done),
        .err_o              (err),
        .pll_locked_i       (pll_locked),
        .mgmt_address_o     (mgmt_address),
        .mgmt_write_o       (mgmt_write),
        .mgmt_writedata_o   (mgmt_writedata),
        .mgmt_waitrequest_i (mgmt_waitrequest)
    );

    pll_cfg_writer #(
        .NUM_C        (3),
        .WITH_FRAC    (0),
        .UNLOCK_WIN   (64),
        .LOCK_TIMEOUT (100)
    ) dut2 (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .req_i              (req2),
        .n_cnt_i            (n_cnt2),
        .m_cnt_i            (m_cnt2),
        .k_frac_i           (k_frac2),
        .c_cnt_i            (c_cnt2),
        .busy_o             (busy2),
        .done_o             (done2),
        .err_o              (err2),
        .pll_locked_i       (pll_locked2),
        .mgmt_address_o     (mgmt_address2),
        .mgmt_write_o       (mgmt_write2),
        .mgmt_writedata_o   (mgmt_writedata2),
        .mgmt_waitrequest_i (mgmt_waitrequest2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Slave: holds waitrequest high for 'stall' cycles on every write.
    initial begin
        mgmt_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mgmt_write && hold < stall) begin
                mgmt_waitrequest = 1'b1;
                hold++;
            end else begin
                mgmt_waitrequest = 1'b0;
                hold = 0;
            end
        end
    end

    // PLL lock model: mode 0 drops lock 3 cycles after start, raises it 20 later.
    initial forever begin
        @(negedge clk);
        if (rst_n && mgmt_write && mgmt_address == 6'h02 && !mgmt_waitrequest) begin
            start_cyc = cyc;
            if (lock_mode == 0) begin
                drop_at = cyc + 3;
                rise_at = cyc + 23;
            end
        end
        if (lock_mode == 0) begin
            if (cyc == drop_at) pll_locked = 1'b0;
            if (cyc == rise_at) pll_locked = 1'b1;
        end
    end

    // Monitor for the main DUT.
    initial forever begin
        @(negedge clk);
        if (rst_n && mgmt_write) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got %0h:%0h required none",
                         mgmt_address, mgmt_writedata);
            end else begin
                chk("write", 64'({mgmt_address, mgmt_writedata}), 64'(exp_q[0]));
                if (!mgmt_waitrequest) begin
                    void'(exp_q.pop_front());
                    wr_cnt++;
                end
            end
        end
        if (rst_n && done) done_cnt++;
    end

    // Monitor for the WITH_FRAC=0 DUT.
    initial forever begin
        @(negedge clk);
        if (rst_n && mgmt_write2) begin
            if (mgmt_address2 == 6'h07) k2_seen++;
            if (exp2_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write2: got %0h:%0h required none",
                         mgmt_address2, mgmt_writedata2);
            end else begin
                chk("write2", 64'({mgmt_address2, mgmt_writedata2}), 64'(exp2_q[0]));
                if (!mgmt_waitrequest2) begin
                    void'(exp2_q.pop_front());
                    wr2_cnt++;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic push_t1();
        exp_q.push_back({6'h00, 32'h0000_0000});
        exp_q.push_back({6'h03, 32'h0001_0000});
        exp_q.push_back({6'h04, 32'h0000_0808});
        exp_q.push_back({6'h07, 32'h6666_6666});
        exp_q.push_back({6'h05, 32'h0000_0303});
        exp_q.push_back({6'h05, 32'h0004_0404});
        exp_q.push_back({6'h05, 32'h0008_0606});
        exp_q.push_back({6'h02, 32'h0000_0001});
    endtask

    task automatic push_t2();
        exp_q.push_back({6'h00, 32'h0000_0000});
        exp_q.push_back({6'h03, 32'h0000_0a0a});
        exp_q.push_back({6'h04, 32'h0001_1e1e});
        exp_q.push_back({6'h07, 32'h1234_5678});
        exp_q.push_back({6'h05, 32'h0000_0202});
        exp_q.push_back({6'h05, 32'h0005_0505});
        exp_q.push_back({6'h05, 32'h000b_ffff});
        exp_q.push_back({6'h02, 32'h0000_0001});
    endtask

    // Issue one request; inputs are scrambled right after acceptance.
    task automatic start_req(input logic [17:0] n, input logic [17:0] m,
                             input logic [31:0] k, input logic [53:0] c);
        @(posedge clk);
        #1;
        n_cnt  = n;
        m_cnt  = m;
        k_frac = k;
        c_cnt  = c;
        req    = 1'b1;
        @(posedge clk);
        #1;
        req    = 1'b0;
        n_cnt  = ~n;
        m_cnt  = ~m;
        k_frac = ~k;
        c_cnt  = ~c;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        if (dcyc < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done required done within %0d", budget);
        end
    endtask

    task automatic find_addr(input logic [5:0] a, input logic need_stall);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (mgmt_write && mgmt_address == a && (!need_stall || mgmt_waitrequest))
                found = 1'b1;
        end
        chk("find_write", 64'(found), 64'd1);
    endtask

    localparam logic [53:0] CT1 = {18'h00606, 18'h00404, 18'h00303};
    localparam logic [53:0] CT2 = {18'h3ffff, 18'h10505, 18'h00202};

    initial begin
        int dc;
        int w0;
        int d0;
        int w2;
        logic ok;
        rst_n = 1'b0;
        req = 1'b0;
        n_cnt = '0;
        m_cnt = '0;
        k_frac = '0;
        c_cnt = '0;
        pll_locked = 1'b1;
        req2 = 1'b0;
        n_cnt2 = '0;
        m_cnt2 = '0;
        k_frac2 = '0;
        c_cnt2 = '0;
        pll_locked2 = 1'b1;
        mgmt_waitrequest2 = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_write", 64'(mgmt_write), 64'd0);
        chk("rst_addr", 64'(mgmt_address), 64'd0);
        chk("rst_data", 64'(mgmt_writedata), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Zero-waitstate run.
        lock_mode = 0;
        stall = 0;
        w0 = wr_cnt;
        d0 = done_cnt;
        push_t1();
        start_req(18'h10000, 18'h00808, 32'h6666_6666, CT1);
        wait_done(300, dc);
        chk("t1_err", 64'(err), 64'd0);
        chk("t1_busy", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        chk("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t1_writes", 64'(wr_cnt - w0), 64'd8);
        chk("t1_left", 64'(exp_q.size()), 64'd0);

        // Waitrequest stalls.
        stall = 5;
        w0 = wr_cnt;
        d0 = done_cnt;
        push_t2();
        start_req(18'h00a0a, 18'h11e1e, 32'h1234_5678, CT2);
        wait_done(600, dc);
        chk("t2_err", 64'(err), 64'd0);
        repeat (5) @(negedge clk);
        chk("t2_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t2_writes", 64'(wr_cnt - w0), 64'd8);
        chk("t2_left", 64'(exp_q.size()), 64'd0);

        // Lock timeout: lock low before the request and never returns.
        stall = 0;
        lock_mode = 1;
        pll_locked = 1'b0;
        repeat (4) @(posedge clk);
        push_t1();
        start_req(18'h10000, 18'h00808, 32'h6666_6666, CT1);
        wait_done(400, dc);
        chk("t3_done_cycle", 64'(dc), 64'(start_cyc + 102));
        chk("t3_err", 64'(err), 64'd1);
        chk("t3_busy", 64'(busy), 64'd0);

        // Lock never drops; next request also clears err.
        lock_mode = 2;
        pll_locked = 1'b1;
        repeat (4) @(posedge clk);
        push_t1();
        start_req(18'h10000, 18'h00808, 32'h6666_6666, CT1);
        chk("t4_err_cleared", 64'(err), 64'd0);
        chk("t4_busy_set", 64'(busy), 64'd1);
        wait_done(300, dc);
        ok = (dc >= start_cyc + 66) && (dc <= start_cyc + 68);
        chk("t4_unlock_win", 64'(ok), 64'd1);
        chk("t4_err", 64'(err), 64'd0);
        chk("t4_left", 64'(exp_q.size()), 64'd0);

        // Second request during a stalled write is ignored.
        stall = 5;
        lock_mode = 0;
        w0 = wr_cnt;
        d0 = done_cnt;
        push_t2();
        start_req(18'h00a0a, 18'h11e1e, 32'h1234_5678, CT2);
        find_addr(6'h04, 1'b1);
        @(posedge clk);
        #1;
        req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        wait_done(600, dc);
        repeat (10) @(negedge clk);
        chk("t5_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t5_writes", 64'(wr_cnt - w0), 64'd8);
        chk("t5_left", 64'(exp_q.size()), 64'd0);

        // WITH_FRAC=0: no K write, seven writes total.
        exp2_q.push_back({6'h00, 32'h0000_0000});
        exp2_q.push_back({6'h03, 32'h0000_0101});
        exp2_q.push_back({6'h04, 32'h0000_0202});
        exp2_q.push_back({6'h05, 32'h0000_0303});
        exp2_q.push_back({6'h05, 32'h0004_0404});
        exp2_q.push_back({6'h05, 32'h0008_0505});
        exp2_q.push_back({6'h02, 32'h0000_0001});
        w2 = wr2_cnt;
        @(posedge clk);
        #1;
        n_cnt2 = 18'h00101;
        m_cnt2 = 18'h00202;
        k_frac2 = 32'hdead_beef;
        c_cnt2 = {18'h00505, 18'h00404, 18'h00303};
        req2 = 1'b1;
        @(posedge clk);
        #1;
        req2 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (done2) ok = 1'b1;
        end
        chk("t6_done2", 64'(ok), 64'd1);
        chk("t6_writes", 64'(wr2_cnt - w2), 64'd7);
        chk("t6_no_k", 64'(k2_seen), 64'd0);
        chk("t6_left", 64'(exp2_q.size()), 64'd0);

        // Reset in the middle of the third write.
        stall = 3;
        lock_mode = 0;
        pll_locked = 1'b1;
        push_t1();
        start_req(18'h10000, 18'h00808, 32'h6666_6666, CT1);
        find_addr(6'h04, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_write", 64'(mgmt_write), 64'd0);
        chk("t7_busy", 64'(busy), 64'd0);
        chk("t7_done", 64'(done), 64'd0);
        chk("t7_err", 64'(err), 64'd0);
        exp_q.delete();
        w0 = wr_cnt;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t7_no_writes", 64'(wr_cnt - w0), 64'd0);
        chk("t7_idle_busy", 64'(busy), 64'd0);

        // Recovery after reset: a fresh request runs the full list.
        stall = 0;
        w0 = wr_cnt;
        push_t1();
        start_req(18'h10000, 18'h00808, 32'h6666_6666, CT1);
        wait_done(300, dc);
        chk("t8_writes", 64'(wr_cnt - w0), 64'd8);
        chk("t8_err", 64'(err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
